// File: rtl/nasti_stream_writer_if.sv
// NASTI (AXI4) write-side bus: AW, W and B channels.
// The master modport is the data mover; the slave modport is the memory.
interface nasti_stream_writer_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]              aw_len;
  logic [2:0]              aw_size;
  logic [1:0]              aw_burst;
  logic                    aw_valid;
  logic                    aw_ready;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_last;
  logic                    w_valid;
  logic                    w_ready;
  logic [1:0]              b_resp;
  logic                    b_valid;
  logic                    b_ready;

  modport master (
    output aw_addr, aw_len, aw_size, aw_burst, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_valid,
    input  w_ready,
    input  b_resp, b_valid,
    output b_ready
  );

  modport slave (
    input  aw_addr, aw_len, aw_size, aw_burst, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_valid,
    output w_ready,
    output b_resp, b_valid,
    input  b_ready
  );
endinterface

// File: rtl/nasti_stream_writer.sv
// Stream-to-memory mover: takes one (dst, len) request, then writes the
// incoming stream to memory as a sequence of INCR bursts, one burst in
// flight at a time (AW, then its W beats, then its B response).
module nasti_stream_writer #(
  parameter int ADDR_WIDTH       = 64,
  parameter int DATA_WIDTH       = 64,
  parameter int MAX_BURST_LENGTH = 8
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [ADDR_WIDTH-1:0] req_dst,
  input  logic [ADDR_WIDTH-1:0] req_len,
  input  logic                  req_valid,
  output logic                  req_ready,
  output logic                  req_err,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  input  logic                  s_valid,
  output logic                  s_ready,
  nasti_stream_writer_if.master m_axi
);

  localparam int SHIFT = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] MAX_BEATS = ADDR_WIDTH'(MAX_BURST_LENGTH);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    RESP
  } state_t;

  state_t                r_state;
  logic                  r_req_ready;
  logic                  r_req_err;
  logic [ADDR_WIDTH-1:0] r_addr;      // next burst start address
  logic [ADDR_WIDTH-1:0] r_beats;     // beats not yet assigned to a burst
  logic [ADDR_WIDTH-1:0] r_aw_addr;
  logic [7:0]            r_aw_len;
  logic                  r_aw_valid;
  logic [7:0]            r_cnt;       // beats left in current burst, minus one
  logic                  r_b_ready;

  logic [ADDR_WIDTH-1:0] w_req_addr;
  logic [ADDR_WIDTH-1:0] w_req_beats;
  logic [ADDR_WIDTH-1:0] w_src_addr;
  logic [ADDR_WIDTH-1:0] w_src_beats;
  logic [ADDR_WIDTH-1:0] w_burst;
  logic [ADDR_WIDTH-1:0] w_next_addr;
  logic [ADDR_WIDTH-1:0] w_next_beats;
  logic [7:0]            w_next_len;
  logic                  w_w_hs;
  logic                  w_last_beat;
  logic                  w_final_beat;
  logic                  w_b_hs;

  // Request values with the sub-word bits dropped.
  assign w_req_addr  = (req_dst >> SHIFT) << SHIFT;
  assign w_req_beats = req_len >> SHIFT;

  // A burst is issued either straight from the request (IDLE) or from the
  // running address/beat registers (after a B response).
  assign w_src_addr   = (r_state == IDLE) ? w_req_addr  : r_addr;
  assign w_src_beats  = (r_state == IDLE) ? w_req_beats : r_beats;
  assign w_burst      = (w_src_beats > MAX_BEATS) ? MAX_BEATS : w_src_beats;
  assign w_next_addr  = w_src_addr + (w_burst << SHIFT);
  assign w_next_beats = w_src_beats - w_burst;
  assign w_next_len   = 8'(w_burst - 1'b1);

  assign w_w_hs       = (r_state == DATA) && s_valid && m_axi.w_ready;
  assign w_last_beat  = (r_cnt == 8'd0);
  assign w_final_beat = w_last_beat && (r_beats == '0);
  assign w_b_hs       = r_b_ready && m_axi.b_valid;

  assign req_ready = r_req_ready;
  assign req_err   = r_req_err;

  assign m_axi.aw_addr  = r_aw_addr;
  assign m_axi.aw_len   = r_aw_len;
  assign m_axi.aw_size  = 3'(SHIFT);
  assign m_axi.aw_burst = 2'b01;
  assign m_axi.aw_valid = r_aw_valid;

  // W is a straight pass-through of the stream while a burst's data phase is open.
  assign m_axi.w_data  = s_data;
  assign m_axi.w_strb  = '1;
  assign m_axi.w_valid = (r_state == DATA) && s_valid;
  assign m_axi.w_last  = (r_state == DATA) && w_last_beat;
  assign s_ready       = (r_state == DATA) && m_axi.w_ready;

  assign m_axi.b_ready = r_b_ready;

  // Control FSM: request accept, burst issue, beat counting, response and error tracking.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state     <= IDLE;
      r_req_ready <= 1'b1;
      r_req_err   <= 1'b0;
      r_addr      <= '0;
      r_beats     <= '0;
      r_aw_addr   <= '0;
      r_aw_len    <= '0;
      r_aw_valid  <= 1'b0;
      r_cnt       <= '0;
      r_b_ready   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!r_req_ready) begin
            // One-cycle busy after an empty request.
            r_req_ready <= 1'b1;
          end else if (req_valid) begin
            r_req_err   <= 1'b0;
            r_req_ready <= 1'b0;
            if (w_req_beats == '0) begin
              r_addr  <= w_req_addr;
              r_beats <= '0;
            end else begin
              r_aw_addr  <= w_src_addr;
              r_aw_len   <= w_next_len;
              r_aw_valid <= 1'b1;
              r_cnt      <= w_next_len;
              r_beats    <= w_next_beats;
              r_addr     <= w_next_addr;
              r_state    <= ADDR;
            end
          end
        end

        ADDR: begin
          if (m_axi.aw_ready) begin
            r_aw_valid <= 1'b0;
            r_state    <= DATA;
          end
        end

        DATA: begin
          if (w_w_hs) begin
            // s_last must coincide exactly with the last beat of the whole request.
            if (w_final_beat != s_last) begin
              r_req_err <= 1'b1;
            end
            if (w_last_beat) begin
              r_b_ready <= 1'b1;
              r_state   <= RESP;
            end else begin
              r_cnt <= r_cnt - 8'd1;
            end
          end
        end

        RESP: begin
          if (w_b_hs) begin
            r_b_ready <= 1'b0;
            if (m_axi.b_resp != 2'b00) begin
              r_req_err <= 1'b1;
            end
            if (r_beats == '0) begin
              r_req_ready <= 1'b1;
              r_state     <= IDLE;
            end else begin
              r_aw_addr  <= w_src_addr;
              r_aw_len   <= w_next_len;
              r_aw_valid <= 1'b1;
              r_cnt      <= w_next_len;
              r_beats    <= w_next_beats;
              r_addr     <= w_next_addr;
              r_state    <= ADDR;
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/nasti_stream_writer.md
Name: nasti_stream_writer

Overview:
Stream-to-memory data mover; write-direction counterpart of the stream reader in nasti-stream. Consumes a NASTI-stream (AXI4-Stream) and writes it to memory via NASTI (AXI4) AW/W/B bursts. Address and length come from a one-shot request handshake. Read channels are unused.

Parameters:
ADDR_WIDTH, 64, width of request address/length and aw_addr
DATA_WIDTH, 64, stream and W data width in bits; power of 2, >= 8
MAX_BURST_LENGTH, 8, max beats per AW burst; 1..256

Ports:
aclk  in  1  clock
aresetn  in  1  reset, synchronous, active-low
req_dst  in  ADDR_WIDTH  destination byte address; low log2(DATA_WIDTH/8) bits ignored
req_len  in  ADDR_WIDTH  length in bytes; low log2(DATA_WIDTH/8) bits ignored
req_valid  in  1  request valid
req_ready  out  1  idle, request accepted when req_valid&&req_ready
req_err  out  1  sticky error for last completed request; cleared on next accept
s_data  in  DATA_WIDTH  stream data
s_last  in  1  stream end-of-packet
s_valid  in  1  stream valid
s_ready  out  1  stream ready
aw_addr  out  ADDR_WIDTH  burst address
aw_len  out  8  beats-1
aw_size  out  3  constant log2(DATA_WIDTH/8)
aw_burst  out  2  constant 2'b01 (INCR)
aw_valid  out  1
aw_ready  in  1
w_data  out  DATA_WIDTH
w_strb  out  DATA_WIDTH/8  constant all ones
w_last  out  1
w_valid  out  1
w_ready  in  1
b_resp  in  2
b_valid  in  1
b_ready  out  1

Behaviour:
- Sync reset (aresetn==0 at posedge): state IDLE, req_ready=1, req_err=0, aw_valid=0, b_ready=0; w_valid/s_ready=0 (gated by state). Reset mid-burst abandons transfer; no AW/W/B draining.
- SHIFT=log2(DATA_WIDTH/8). Internal addr/remaining-beats regs: addr=req_dst with low SHIFT bits zeroed; beats=req_len>>SHIFT.
- States IDLE, ADDR, DATA, RESP, one burst outstanding at a time.
- IDLE: req_ready=1. On req_valid: latch addr/beats, clear req_err, req_ready<=0; beats==0 -> stay IDLE with req_ready back to 1 next cycle (one-cycle busy, no bus traffic); else -> ADDR.
- ADDR entry: register aw_addr=addr, aw_len=min(beats,MAX_BURST_LENGTH)-1, aw_valid=1; burst counter=aw_len; beats-=burst; addr+=burst<<SHIFT. Hold aw_* stable until aw_ready; then aw_valid<=0, -> DATA. AW and W never overlap.
- DATA: combinational pass-through w_data=s_data, w_valid=s_valid, s_ready=w_ready. w_last=(burst counter==0). Each w_valid&&w_ready decrements counter; handshake with w_last -> RESP, b_ready<=1.
- s_last check: beat that is final of whole request (w_last and beats==0) without s_last -> req_err<=1; s_last on any other beat -> req_err<=1. Data still written; s_last never truncates transfer.
- RESP: on b_valid&&b_ready: b_ready<=0; b_resp!=2'b00 -> req_err<=1; beats==0 -> IDLE, req_ready<=1; else -> ADDR (next burst). Error does not abort remaining bursts.
- Latency: req accept to aw_valid = 1 cycle; B handshake to next aw_valid = 1 cycle; B to req_ready = 1 cycle.
- No 4KB-boundary splitting; caller keeps bursts within 4KB (aligned addr with MAX_BURST_LENGTH*DATA_WIDTH/8 dividing 4096 is sufficient).
- Address arithmetic wraps modulo 2^ADDR_WIDTH; no overflow detection.
- req_valid ignored while req_ready=0.

Test Plan:
- Defaults, req_dst=0x1000, req_len=0x40, 8-beat stream with s_last on beat 8, aw_ready/w_ready/b_valid always 1 -> one AW addr 0x1000 len 7; w_last on beat 8; req_ready high again 1 cycle after B; req_err=0.
- req_len=0x58 (11 beats) -> AW 0x1000 len 7 then AW 0x1040 len 2; second AW only after first B; 11 W beats total.
- req_len=0 -> no aw_valid/w_valid; req_ready low exactly 1 cycle.
- Random s_valid/w_ready stalls and aw_ready delayed 5 cycles -> aw_* stable while waiting; W data order equals stream order; no beat lost or duplicated.
- b_resp=2'b10 on first of two bursts -> second burst still issued; req_err=1 at completion; cleared on next request accept.
- s_last on beat 3 of 8-beat request -> all 8 beats written, req_err=1; aresetn low mid-DATA -> next cycle req_ready=1, aw_valid=0, s_ready=0.
